// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: accepts one multiply job at a time, drives an external
// shift-add multiplier through a start/ready handshake, and returns the product
// (or a zero error result if the multiplier does not answer within TIMEOUT
// cycles).
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   in_valid/in_ready          upstream job handshake, operands in_a/in_b
//   out_valid/out_ready        downstream result handshake
//   out_product, out_err       result and "produced by timeout" marker
//   mul_start                  one-cycle start pulse to the multiplier
//   mul_word0, mul_word1       operands held for the multiplier
//   mul_ready, mul_product     multiplier idle flag and result
//   timeout_flag               sticky timeout indicator, cleared by reset only
module mult_job_sequencer #(
  parameter int unsigned word_length = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [word_length-1:0]     in_a,
  input  logic [word_length-1:0]     in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*word_length-1:0]   out_product,
  output logic                       out_err,
  output logic                       mul_start,
  output logic [word_length-1:0]     mul_word0,
  output logic [word_length-1:0]     mul_word1,
  input  logic                       mul_ready,
  input  logic [2*word_length-1:0]   mul_product,
  output logic                       timeout_flag
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t                     r_state;
  logic [8:0]                 r_cnt;
  logic [2*word_length-1:0]   r_product;
  logic                       r_err;
  logic                       r_timeout_flag;
  logic [word_length-1:0]     r_word0;
  logic [word_length-1:0]     r_word1;

  logic [8:0]                 w_cnt_inc;
  logic                       w_timeout;
  logic                       w_exit;
  logic                       w_bypass;

  // Nine bits so the count can pass TIMEOUT=255 without wrapping.
  assign w_cnt_inc = r_cnt + 9'd1;
  assign w_timeout = (w_cnt_inc >= 9'(TIMEOUT));
  assign w_bypass  = (in_a == '0) || (in_b == '0);

  // Exit condition of the current waiting state; it wins over a timeout.
  always_comb begin
    w_exit = 1'b0;
    unique case (r_state)
      ISSUE:     w_exit = mul_ready;
      WAIT_BUSY: w_exit = !mul_ready;
      WAIT_DONE: w_exit = mul_ready;
      default:   w_exit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_product      <= '0;
      r_err          <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_word0        <= '0;
      r_word1        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word0 <= in_a;
            r_word1 <= in_b;
            if (w_bypass) begin
              r_product <= '0;
              r_err     <= 1'b0;
              r_state   <= DONE;
            end else begin
              r_cnt   <= '0;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE, WAIT_BUSY, WAIT_DONE: begin
          r_cnt <= w_cnt_inc;
          if (w_exit) begin
            unique case (r_state)
              ISSUE:     r_state <= WAIT_BUSY;
              WAIT_BUSY: r_state <= WAIT_DONE;
              default: begin
                r_product <= mul_product;
                r_err     <= 1'b0;
                r_state   <= DONE;
              end
            endcase
          end else if (w_timeout) begin
            r_product      <= '0;
            r_err          <= 1'b1;
            r_timeout_flag <= 1'b1;
            r_state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE) && !reset;
  // Start only while the multiplier reports idle; stays in ISSUE otherwise.
  assign mul_start    = (r_state == ISSUE) && mul_ready && !reset;
  assign out_valid    = (r_state == DONE);
  assign out_product  = r_product;
  assign out_err      = r_err;
  assign mul_word0    = r_word0;
  assign mul_word1    = r_word1;
  assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_mult_job_sequencer.sv
module tb_mult_job_sequencer;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_product;
  logic           out_err;
  logic           mul_start;
  logic [W-1:0]   mul_word0;
  logic [W-1:0]   mul_word1;
  logic           mul_ready;
  logic [2*W-1:0] mul_product;
  logic           timeout_flag;

  mult_job_sequencer #(
    .word_length(W),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_err     (out_err),
    .mul_start   (mul_start),
    .mul_word0   (mul_word0),
    .mul_word1   (mul_word1),
    .mul_ready   (mul_ready),
    .mul_product (mul_product),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Multiplier model: drops ready the cycle after start, raises it busy_len
  // cycles later with the product. In stuck mode ready never drops.
  int             busy_len = 4;
  bit             stuck = 1'b0;
  int             m_cnt;
  logic           m_ready;
  logic [2*W-1:0] m_prod;

  always @(posedge clk) begin
    if (reset) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_prod  <= '0;
    end else if (stuck) begin
      m_ready <= 1'b1;
    end else if (mul_start) begin
      m_ready <= 1'b0;
      m_cnt   <= busy_len;
      m_prod  <= '0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        m_prod  <= (2*W)'(mul_word0) * (2*W)'(mul_word1);
      end
    end
  end
  assign mul_ready   = m_ready;
  assign mul_product = m_prod;

  // Scoreboard: {err, product} expected per accepted job.
  logic [2*W:0] sb_q[$];

  always @(negedge clk) begin
    if (mul_start) n_start++;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        logic [2*W:0] e;
        e = sb_q.pop_front();
        chk("out_product", int'(out_product), int'(e[2*W-1:0]));
        chk("out_err", int'(out_err), int'(e[2*W]));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                      input int exp_p, input bit exp_e);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb_q.push_back({exp_e, (2*W)'(exp_p)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && in_ready) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  int s0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("in_ready_in_reset", int'(in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_mul_start", int'(mul_start), 0);
    chk("rst_words", int'({mul_word0, mul_word1}), 0);
    chk("rst_product", int'(out_product), 0);
    chk("rst_err", int'(out_err), 0);
    chk("rst_timeout_flag", int'(timeout_flag), 0);

    // 3*5 through the multiplier
    s0 = n_start;
    send(4'd3, 4'd5, 1'b1, 15, 1'b0);
    wait_idle();
    chk("starts_3x5", n_start - s0, 1);
    chk("words_held", int'({mul_word0, mul_word1}), 8'h35);

    // 0*7 bypass: result in the cycle right after acceptance, no start
    s0 = n_start;
    send(4'd0, 4'd7, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("bypass_latency", int'(out_valid), 1);
    wait_idle();
    chk("starts_bypass", n_start - s0, 0);

    // 15*15 with downstream back-pressure
    out_ready = 1'b0;
    send(4'd15, 4'd15, 1'b1, 225, 1'b0);
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_product", int'(out_product), 225);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("idle_after_ready", int'(in_ready), 1);

    // 2*3 with mul_ready stuck high: timeout after 16 wait cycles
    stuck = 1'b1;
    s0 = n_start;
    send(4'd2, 4'd3, 1'b1, 0, 1'b1);
    repeat (15) @(negedge clk);
    @(negedge clk);
    chk("timeout_not_early", int'(out_valid), 0);
    @(negedge clk);
    chk("timeout_on_time", int'(out_valid), 1);
    wait_idle();
    chk("starts_timeout", n_start - s0, 1);
    repeat (3) @(negedge clk);
    chk("timeout_flag_sticky", int'(timeout_flag), 1);
    stuck = 1'b0;

    // Reset during WAIT_DONE abandons the job
    busy_len = 10;
    send(4'd4, 4'd5, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("in_ready_mid_reset", int'(in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_words", int'({mul_word0, mul_word1}), 0);
    chk("post_rst_flag", int'(timeout_flag), 0);
    s0 = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) s0++;
    end
    chk("no_result_after_rst", s0, 0);

    // Back-to-back 4*4 then 6*2
    busy_len = 4;
    s0 = n_start;
    send(4'd4, 4'd4, 1'b1, 16, 1'b0);
    send(4'd6, 4'd2, 1'b1, 12, 1'b0);
    wait_idle();
    chk("starts_b2b", n_start - s0, 2);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
